// File: rtl/i2c_pkg.sv
// i2c_pkg: shared defaults and helpers for the I2C bus monitor and subordinate
package i2c_pkg;

    localparam int I2C_SYNC_STAGES = 2;
    localparam int I2C_FILTER_LEN  = 3;
    localparam int I2C_TIMEOUT     = 1000;

    // Counter width able to hold 0..n, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchroniser plus stability filter for one open-drain line, idles at 1
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int FILTER_LEN  = I2C_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    localparam int CW = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] F_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // Shift the raw level in, then accept it only after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
            q_o  <= 1'b1;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d_i};
            if (s == q_o) begin
                cnt <= '0;
            end else if (cnt == F_LAST) begin
                q_o <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: filtered SCL/SDA, registered bus-condition strobes, busy tracking and SCL-low timeout
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int FILTER_LEN  = I2C_FILTER_LEN,
    parameter int TIMEOUT     = I2C_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic rstart,
    output logic stop,
    output logic busy,
    output logic timeout
);

    localparam int TW = cnt_width(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic          scl_q, sda_q;
    logic          start_c, stop_c, fire;
    logic [TW-1:0] tcnt;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .clk (clk),
        .rst (rst),
        .d_i (scl_i),
        .q_o (scl_f)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .clk (clk),
        .rst (rst),
        .d_i (sda_i),
        .q_o (sda_f)
    );

    // Bus conditions need SCL high on both sides of the SDA edge, so a simultaneous SCL change is data
    always_comb begin
        start_c = sda_q & ~sda_f & scl_q & scl_f;
        stop_c  = ~sda_q & sda_f & scl_q & scl_f;
        fire    = (TIMEOUT != 0) && busy && !scl_f && (tcnt == T_LAST);
    end

    // Delayed lines, registered strobes, busy flag and saturating SCL-low counter
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            rstart   <= 1'b0;
            stop     <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
            tcnt     <= '0;
        end else begin
            scl_q    <= scl_f;
            sda_q    <= sda_f;
            scl_rise <= ~scl_q & scl_f;
            scl_fall <= scl_q & ~scl_f;
            start    <= start_c;
            rstart   <= start_c & busy;
            stop     <= stop_c;
            timeout  <= fire;
            busy     <= start_c ? 1'b1 : (stop_c | fire) ? 1'b0 : busy;
            tcnt     <= (!busy || scl_f || fire) ? '0 : (tcnt == T_LAST) ? tcnt : tcnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor: directed checks of filtering, bus conditions, busy and timeout
module tb_i2c_bus_monitor;

    logic clk = 1'b0;
    logic rst, scl_i, sda_i;
    logic scl_f, sda_f, scl_rise, scl_fall, start, rstart, stop, busy, timeout;
    logic t_scl_f, t_sda_f, t_scl_rise, t_scl_fall, t_start, t_rstart, t_stop, t_busy, t_timeout;
    logic [5:0] ev, t_ev;
    int total = 0;
    int bad = 0;

    localparam logic [5:0] E_RISE = 6'b100000;
    localparam logic [5:0] E_FALL = 6'b010000;
    localparam logic [5:0] E_STA  = 6'b001000;
    localparam logic [5:0] E_RSTA = 6'b001100;
    localparam logic [5:0] E_STO  = 6'b000010;
    localparam logic [5:0] E_TMO  = 6'b000001;

    always #5 clk = ~clk;

    assign ev   = {scl_rise, scl_fall, start, rstart, stop, timeout};
    assign t_ev = {t_scl_rise, t_scl_fall, t_start, t_rstart, t_stop, t_timeout};

    i2c_bus_monitor dut (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
        .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start(start), .rstart(rstart), .stop(stop), .busy(busy), .timeout(timeout)
    );

    i2c_bus_monitor #(.TIMEOUT(50)) dut_t (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
        .scl_f(t_scl_f), .sda_f(t_sda_f), .scl_rise(t_scl_rise), .scl_fall(t_scl_fall),
        .start(t_start), .rstart(t_rstart), .stop(t_stop), .busy(t_busy), .timeout(t_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps n falling edges; the default DUT must show exp on the last one and nothing before or after
    task automatic expect_ev(input string tag, input int n, input logic [5:0] exp);
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge clk);
            chk(tag, 32'(ev), 32'((i == n) ? exp : 6'b0));
        end
    endtask

    initial begin
        rst = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lines", 32'({scl_f, sda_f}), 32'd3);
        chk("rst_ev", 32'(ev), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", 32'({ev, scl_f, sda_f, busy}), 32'({6'b0, 1'b1, 1'b1, 1'b0}));
        end
        // Plain START then STOP
        sda_i = 1'b0;
        expect_ev("start", 6, E_STA);
        chk("start_busy", 32'(busy), 32'd1);
        sda_i = 1'b1;
        expect_ev("stop", 6, E_STO);
        chk("stop_busy", 32'(busy), 32'd0);
        // Repeated START
        sda_i = 1'b0;
        expect_ev("rs_start", 6, E_STA);
        scl_i = 1'b0;
        expect_ev("rs_fall", 6, E_FALL);
        sda_i = 1'b1;
        expect_ev("rs_data", 7, 6'b0);
        scl_i = 1'b1;
        expect_ev("rs_rise", 6, E_RISE);
        chk("rs_busy_pre", 32'(busy), 32'd1);
        sda_i = 1'b0;
        expect_ev("rstart", 6, E_RSTA);
        chk("rs_busy_post", 32'(busy), 32'd1);
        sda_i = 1'b1;
        expect_ev("rs_stop", 6, E_STO);
        chk("rs_busy_end", 32'(busy), 32'd0);
        // Two-clock glitch is rejected
        sda_i = 1'b0;
        repeat (2) @(negedge clk);
        sda_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("glitch2", 32'({ev, sda_f, busy}), 32'({6'b0, 1'b1, 1'b0}));
        end
        // Three-clock glitch passes: START at 6, STOP at 9
        sda_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 3) sda_i = 1'b1;
            chk("glitch3", 32'(ev), 32'((i == 6) ? E_STA : (i == 9) ? E_STO : 6'b0));
            if (i == 6) chk("glitch3_busy", 32'(busy), 32'd1);
            if (i == 9) chk("glitch3_idle", 32'(busy), 32'd0);
        end
        // Simultaneous SCL/SDA change is data, not a bus condition
        scl_i = 1'b0; sda_i = 1'b0;
        expect_ev("simul_fall", 6, E_FALL);
        scl_i = 1'b1; sda_i = 1'b1;
        expect_ev("simul_rise", 6, E_RISE);
        chk("simul_busy", 32'(busy), 32'd0);
        // Timeout on the TIMEOUT=50 instance: fires 50 clocks after its filtered SCL falls
        sda_i = 1'b0;
        expect_ev("to_start", 6, E_STA);
        chk("to_tbusy", 32'(t_busy), 32'd1);
        scl_i = 1'b0;
        for (int i = 1; i <= 56; i++) begin
            @(negedge clk);
            chk("to_ev", 32'(t_ev), 32'((i == 6) ? E_FALL : (i == 55) ? E_TMO : 6'b0));
            if (i == 5) chk("to_sclf", 32'(t_scl_f), 32'd0);
            if (i == 54) chk("to_busy_hold", 32'(t_busy), 32'd1);
            if (i == 55) chk("to_busy_drop", 32'(t_busy), 32'd0);
        end
        // Reset mid-transaction on the default instance
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ev", 32'(ev), 32'd0);
        chk("mid_rst_sclf", 32'(scl_f), 32'd1);
        scl_i = 1'b1; sda_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst", 32'({ev, busy}), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
